// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM encoding and baud/oversampling constants
// used by both the transmitter and the receiver.
package uart_pkg;

    // s_tick pulses per bit period on the shared baud enable.
    localparam int unsigned OVERSAMPLE = 16;

    // Tick counter width: large enough to count the longest stop period.
    localparam int unsigned TICK_W = 5;

    // Receiver: tick within the start bit at which the line is re-sampled
    // to confirm a genuine start (mid-bit).
    localparam int unsigned START_MID_TICK = OVERSAMPLE / 2 - 1;

    // Allowed stop periods, in s_ticks.
    localparam int unsigned STOP_TICK_1   = 16;
    localparam int unsigned STOP_TICK_1P5 = 24;
    localparam int unsigned STOP_TICK_2   = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // True when t is one of the supported stop periods.
    function automatic bit stop_tick_valid(input int unsigned t);
        return (t == STOP_TICK_1) || (t == STOP_TICK_1P5) || (t == STOP_TICK_2);
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: serialises din_i LSB-first as start, data, optional
// parity and stop bits, paced by the shared 16x s_tick baud enable.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0,
    parameter int unsigned STOP_TICK  = STOP_TICK_1
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  s_tick,
    input  logic                  tx_start_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic                  tx_o,
    output logic                  tx_busy_o,
    output logic                  tx_done_o
);

    localparam int unsigned       BIT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(STOP_TICK - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_WIDTH - 1);

    uart_state_e           state_q, state_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;

    // State and datapath registers; reset forces the line high immediately.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: frame sequencing, tick/bit counting and shifting.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_start_i) begin
                    shift_d  = din_i;
                    tick_d   = '0;
                    parity_d = 1'b0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (tick_q == LAST_TICK) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (tick_q == LAST_TICK) begin
                        tick_d   = '0;
                        parity_d = parity_q ^ shift_q[0];
                        shift_d  = shift_q >> 1;
                        if (bit_q == LAST_BIT) begin
                            state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (s_tick) begin
                    if (tick_q == LAST_TICK) begin
                        tick_d  = '0;
                        state_d = ST_STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (tick_q == STOP_LAST) begin
                        tick_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: begin
                tick_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: line level is decoded from the next state so the
    // registered tx_o changes on the same edge as the state transition.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = parity_d ^ PARITY_ODD;
            default:   tx_d = 1'b1;
        endcase
        done_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
    end

    assign tx_o      = tx_q;
    assign tx_busy_o = (state_q != ST_IDLE);
    assign tx_done_o = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: four parameterisations driven by directed
// frames; a line-level receiver per instance decodes tx_o and checks it
// against the queued expected frame.
`timescale 1ns/1ps
module tb_uart_tx;

    typedef struct {
        logic [7:0] data;
        bit         par_en;
        logic       par_bit;
        int         b;      // clocks per bit period
        int         total;  // clocks from acceptance to tx_done_o
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] tick_v = 4'hF;
    logic [3:0] start_v = 4'h0;
    logic [7:0] din_v [4];
    wire  [3:0] tx_v;
    wire  [3:0] busy_v;
    wire  [3:0] done_v;

    exp_t sb [4][$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   exp_done [4];
    int   rx_frames [4];
    int   done_cnt [4];

    // 0: defaults, 1: even parity, 2: odd parity, 3: two stop bits (s_tick every 4th clk)
    uart_tx #(.DATA_WIDTH(8)) u_def (
        .clk(clk), .rst_i(rst), .s_tick(tick_v[0]), .tx_start_i(start_v[0]), .din_i(din_v[0]),
        .tx_o(tx_v[0]), .tx_busy_o(busy_v[0]), .tx_done_o(done_v[0]));
    uart_tx #(.DATA_WIDTH(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even (
        .clk(clk), .rst_i(rst), .s_tick(tick_v[1]), .tx_start_i(start_v[1]), .din_i(din_v[1]),
        .tx_o(tx_v[1]), .tx_busy_o(busy_v[1]), .tx_done_o(done_v[1]));
    uart_tx #(.DATA_WIDTH(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
        .clk(clk), .rst_i(rst), .s_tick(tick_v[2]), .tx_start_i(start_v[2]), .din_i(din_v[2]),
        .tx_o(tx_v[2]), .tx_busy_o(busy_v[2]), .tx_done_o(done_v[2]));
    uart_tx #(.DATA_WIDTH(8), .STOP_TICK(32)) u_stop2 (
        .clk(clk), .rst_i(rst), .s_tick(tick_v[3]), .tx_start_i(start_v[3]), .din_i(din_v[3]),
        .tx_o(tx_v[3]), .tx_busy_o(busy_v[3]), .tx_done_o(done_v[3]));

    always #5 clk = ~clk;

    // Baud enables: instances 0-2 tick every clk, instance 3 every 4th clk.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            tick_v = {(cyc % 4 == 0), 3'b111};
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Line receivers: detect the start bit on tx_o and verify every sample.
    for (genvar g = 0; g < 4; g++) begin : g_rx
        initial begin
            exp_t       e;
            int         nseg;
            int         seg;
            int         mism [12];
            logic       exp_bit;
            logic [7:0] dec;
            bit         aborted;
            bit         early_done;
            bit         busy_drop;
            forever begin
                @(negedge clk);
                if (rst !== 1'b0 || tx_v[g] !== 1'b0) continue;
                if (sb[g].size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx%0d unexpected start bit: got frame, expected none", g);
                    for (int w = 0; w < 2000 && tx_v[g] === 1'b0; w++) @(negedge clk);
                    continue;
                end
                e = sb[g].pop_front();
                nseg = e.par_en ? 11 : 10;
                for (int s = 0; s < 12; s++) mism[s] = 0;
                dec = '0;
                aborted = 1'b0;
                early_done = 1'b0;
                busy_drop = 1'b0;
                for (int i = 0; i < e.total; i++) begin
                    if (i > 0) @(negedge clk);
                    if (rst !== 1'b0) begin
                        aborted = 1'b1;
                        break;
                    end
                    seg = i / e.b;
                    if (seg > nseg - 1) seg = nseg - 1;
                    if (seg == 0) exp_bit = 1'b0;
                    else if (seg <= 8) exp_bit = e.data[seg-1];
                    else if (seg == 9 && e.par_en) exp_bit = e.par_bit;
                    else exp_bit = 1'b1;
                    if (tx_v[g] !== exp_bit) mism[seg]++;
                    if ((i % e.b) == (e.b / 2) && seg >= 1 && seg <= 8) dec[seg-1] = tx_v[g];
                    if (done_v[g] !== 1'b0) early_done = 1'b1;
                    if (busy_v[g] !== 1'b1) busy_drop = 1'b1;
                end
                if (aborted) continue;
                for (int s = 0; s < nseg; s++)
                    check($sformatf("rx%0d data %02h segment %0d bad samples", g, e.data, s), mism[s], 0);
                check($sformatf("rx%0d dout", g), dec, e.data);
                check($sformatf("rx%0d done before frame end", g), early_done, 0);
                check($sformatf("rx%0d busy dropped mid-frame", g), busy_drop, 0);
                @(negedge clk);
                check($sformatf("rx%0d done at frame end", g), done_v[g], 1);
                check($sformatf("rx%0d busy at frame end", g), busy_v[g], 0);
                rx_frames[g]++;
            end
        end

        initial begin
            forever begin
                @(negedge clk);
                if (done_v[g] === 1'b1) done_cnt[g]++;
            end
        end
    end

    task automatic push_exp(input int k, input logic [7:0] d, input logic pb, input int total,
                            input bit completes);
        exp_t e;
        e.data    = d;
        e.par_en  = (k == 1 || k == 2);
        e.par_bit = pb;
        e.b       = (k == 3) ? 64 : 16;
        e.total   = total;
        sb[k].push_back(e);
        if (completes) exp_done[k]++;
    endtask

    task automatic send(input int k, input logic [7:0] d, input logic pb, input int total,
                        input bit completes);
        push_exp(k, d, pb, total, completes);
        @(negedge clk); #1;
        while (k == 3 && (cyc % 4) != 0) begin
            @(negedge clk); #1;
        end
        din_v[k] = d;
        start_v[k] = 1'b1;
        @(negedge clk); #1;
        start_v[k] = 1'b0;
    endtask

    task automatic wait_frames(input int k, input int budget);
        int n;
        n = 0;
        while (rx_frames[k] != exp_done[k] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("inst%0d frames completed in budget", k), rx_frames[k], exp_done[k]);
        @(negedge clk); #1;
    endtask

    initial begin
        int n;
        logic [7:0] d;
        for (int k = 0; k < 4; k++) din_v[k] = 8'h00;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset tx_o", tx_v, 4'hF);
        check("reset tx_busy_o", busy_v, 4'h0);
        check("reset tx_done_o", done_v, 4'h0);
        #1 rst = 1'b0;

        // Basic frame, even/odd parity, two stop bits with slow s_tick.
        send(0, 8'hA5, 1'b0, 160, 1'b1);
        wait_frames(0, 400);
        send(1, 8'hA5, 1'b0, 176, 1'b1);
        wait_frames(1, 400);
        send(2, 8'hA5, 1'b1, 176, 1'b1);
        wait_frames(2, 400);
        send(1, 8'h01, 1'b1, 176, 1'b1);
        wait_frames(1, 400);
        send(3, 8'h00, 1'b0, 704, 1'b1);
        wait_frames(3, 1500);

        // Start while busy is ignored; start in the done cycle is accepted.
        send(0, 8'hA5, 1'b0, 160, 1'b1);
        repeat (40) @(negedge clk);
        #1;
        din_v[0] = 8'hFF;
        start_v[0] = 1'b1;
        @(negedge clk); #1;
        start_v[0] = 1'b0;
        din_v[0] = 8'h00;
        n = 0;
        while (done_v[0] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("inst0 done seen before back-to-back start", done_v[0], 1);
        #1;
        push_exp(0, 8'h3C, 1'b0, 160, 1'b1);
        din_v[0] = 8'h3C;
        start_v[0] = 1'b1;
        @(negedge clk); #1;
        start_v[0] = 1'b0;
        check("back-to-back start bit with no gap", tx_v[0], 0);
        check("back-to-back busy", busy_v[0], 1);
        wait_frames(0, 400);

        // Asynchronous reset mid-DATA aborts the frame at once.
        send(0, 8'hC3, 1'b0, 160, 1'b0);
        repeat (50) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async reset tx_o high immediately", tx_v[0], 1);
        check("async reset busy low immediately", busy_v[0], 0);
        check("async reset no done", done_v[0], 0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        check("aborted frame dropped by receiver", sb[0].size(), 0);
        send(0, 8'h5A, 1'b0, 160, 1'b1);
        wait_frames(0, 400);

        // Loopback of random words through the line receiver.
        for (int i = 0; i < 256; i++) begin
            d = 8'($urandom_range(0, 255));
            send(0, d, 1'b0, 160, 1'b1);
            wait_frames(0, 400);
        end

        repeat (5) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("inst%0d tx_done_o count", k), done_cnt[k], exp_done[k]);
            check($sformatf("inst%0d received frame count", k), rx_frames[k], exp_done[k]);
            check($sformatf("inst%0d scoreboard empty", k), sb[k].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #4_000_000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter: the transmit-side counterpart of the team's 16x-oversampled UART receiver.
- Accepts a parallel word on a single-cycle start strobe and serialises it LSB-first onto tx_o: start bit, data bits, optional parity bit, stop bits.
- Bit timing is driven by the shared s_tick baud enable (16 ticks per bit), so both directions share one baud generator.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (5..9).
- PARITY_EN, 0, 1 = insert a parity bit after the data bits.
- PARITY_ODD, 0, with PARITY_EN=1: 0 = even parity, 1 = odd parity.
- STOP_TICK, 16, s_ticks spent in the stop state: 16 = 1 stop bit, 24 = 1.5, 32 = 2.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- s_tick  input  1  baud enable, 16 pulses per bit period, each one clk wide.
- tx_start_i  input  1  request strobe; sampled only when idle.
- din_i  input  DATA_WIDTH  word to send; captured in the same cycle tx_start_i is accepted.
- tx_o  output  1  serial line, idle high, registered.
- tx_busy_o  output  1  high from the acceptance edge until the frame completes.
- tx_done_o  output  1  one-clk pulse when the last stop tick completes.

Behaviour:
- Reset (asynchronous, active-high):
  - State is IDLE; tx_o=1; tx_busy_o=0; tx_done_o=0.
  - Tick counter, bit counter, shift register and parity accumulator are cleared.
  - Reset asserted mid-frame aborts the frame immediately: tx_o goes high without waiting for a clock edge, and no tx_done_o is produced.
- Registers:
  - Tick counter: 5 bits, wide enough for STOP_TICK up to 32.
  - Bit counter: clog2(DATA_WIDTH) bits.
  - Shift register: DATA_WIDTH bits.
  - Parity accumulator: 1 bit.
  - tx_o is driven from a flop, never combinationally.
- IDLE:
  - tx_o=1.
  - If tx_start_i=1 at an edge: load din_i into the shift register; clear tick counter and parity; go to START. tx_busy_o and tx_o=0 take effect at that same edge.
  - s_tick is irrelevant in IDLE.
- START:
  - tx_o=0.
  - On each s_tick, increment the tick counter.
  - On the s_tick where tick==15: tick=0, bit=0, go to DATA, and drive tx_o=shift[0] at that edge.
- DATA:
  - tx_o=shift[0].
  - On the s_tick where tick==15: tick=0; parity ^= shift[0]; shift right by one.
  - If bit==DATA_WIDTH-1, go to PARITY when PARITY_EN=1, otherwise STOP. Otherwise bit++.
- PARITY (only when PARITY_EN=1):
  - tx_o = parity ^ PARITY_ODD.
  - Lasts 16 ticks, then go to STOP.
- STOP:
  - tx_o=1.
  - On the s_tick where tick==STOP_TICK-1: go to IDLE; tx_done_o=1 for exactly the next cycle; tx_busy_o=0 at that same edge.
- Frame length in s_ticks: 16 × (1 + DATA_WIDTH + PARITY_EN) + STOP_TICK.
- Boundary conditions:
  - tx_start_i while busy is ignored; it is neither queued nor able to corrupt the shift register.
  - din_i changes after acceptance have no effect.
  - tx_start_i asserted in the tx_done_o cycle is accepted, because state is IDLE that cycle. This gives back-to-back frames with no extra idle time beyond the stop bits.
  - s_tick held high continuously is legal: one tick per clk.
  - s_tick low stalls all counters with tx_o held steady.
  - Unreachable state encodings go to IDLE with tx_o=1.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding IDLE/START/DATA/PARITY/STOP as a typedef enum;
  - the constant OVERSAMPLE=16;
  - the allowed STOP_TICK values.
- The receiver's constants should migrate into this package.
- No sub-module. The baud/s_tick generator stays external and shared by receiver and transmitter.

Test Plan:
1. s_tick tied high, default params, pulse tx_start_i with din_i=0xA5 → tx_o low for 16 clks, then data bits 1,0,1,0,0,1,0,1 at 16 clks each, then high for 16 clks. tx_busy_o high for 160 clks; tx_done_o pulses once at clk 160 after acceptance.
2. PARITY_EN=1, PARITY_ODD=0, din_i=0xA5 → parity bit 0, frame 176 ticks. Repeat with PARITY_ODD=1 → parity bit 1. Also din_i=0x01 even → parity bit 1.
3. STOP_TICK=32, s_tick every 4th clk, din_i=0x00 → stop bit high for 128 clks; total frame 16×9×4+128 = 704 clks to tx_done_o.
4. Assert tx_start_i again with din_i=0xFF during DATA → ignored; the first frame bits are unchanged and only one tx_done_o occurs. Then assert tx_start_i in the tx_done_o cycle with 0x3C → the next start bit begins on the following edge with no idle gap.
5. Assert rst_i asynchronously mid-DATA (between clk edges) → tx_o=1 and tx_busy_o=0 immediately, no tx_done_o. After release, a new 0x5A frame transmits correctly.
6. Loopback: tx_o wired to the existing receiver, sharing s_tick, with 256 random words → the receiver's dout_o matches every word, and the receiver's rx_done_o count equals the tx_done_o count.
